// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : shift_engine
//  Brief    : Multi-cycle shift/rotate engine. Takes an operand through a
//             valid/ready handshake, shifts it up to STEP bits per clock and
//             returns the result with carry-out and zero flags through a
//             second valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_engine #(
  parameter int  WIDTH = 16,
  parameter int  STEP  = 1,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] shift_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             carry_out,
  output logic             zero
);

  // Mode encodings of the sel input
  localparam logic [2:0] c_sel_none = 3'b000;
  localparam logic [2:0] c_sel_lsl  = 3'b001;
  localparam logic [2:0] c_sel_asl  = 3'b010;
  localparam logic [2:0] c_sel_lsr  = 3'b011;
  localparam logic [2:0] c_sel_asr  = 3'b100;
  localparam logic [2:0] c_sel_rol  = 3'b101;
  localparam logic [2:0] c_sel_ror  = 3'b110;
  localparam logic [2:0] c_sel_rsvd = 3'b111;

  localparam logic [CNT_W-1:0] c_step = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_work;       // operand being shifted
  logic [2:0]       r_sel;        // mode captured at accept
  logic [CNT_W-1:0] r_remaining;  // bits still to shift

  logic [CNT_W-1:0] w_n;          // bits shifted this cycle
  logic [CNT_W-1:0] w_lidx;       // WIDTH-n: last bit out on a left move
  logic [CNT_W-1:0] w_ridx;       // n-1: last bit out on a right move
  logic [WIDTH-1:0] w_shifted;
  logic             w_carry;
  logic [CNT_W-1:0] w_rem_next;
  logic             w_noop;

  // A zero count or a mode with no shift skips the SHIFT state entirely
  assign w_noop = (shift_count == c_zero) || (sel == c_sel_none) || (sel == c_sel_rsvd);

  // One shift step of up to STEP bits on the working register
  always_comb begin
    w_n        = (r_remaining < c_step) ? r_remaining : c_step;
    // WIDTH is a power of two, so WIDTH-n wraps correctly in CNT_W bits
    w_lidx     = c_zero - w_n;
    w_ridx     = w_n - c_one;
    w_rem_next = r_remaining - w_n;
    w_shifted  = r_work;
    w_carry    = 1'b0;
    case (r_sel)
      c_sel_lsl, c_sel_asl: begin
        w_shifted = r_work << w_n;
        w_carry   = r_work[w_lidx];
      end
      c_sel_lsr: begin
        w_shifted = r_work >> w_n;
        w_carry   = r_work[w_ridx];
      end
      c_sel_asr: begin
        w_shifted = $signed(r_work) >>> w_n;
        w_carry   = r_work[w_ridx];
      end
      c_sel_rol: begin
        w_shifted = (r_work << w_n) | (r_work >> w_lidx);
        w_carry   = r_work[w_lidx];
      end
      c_sel_ror: begin
        w_shifted = (r_work >> w_n) | (r_work << w_lidx);
        w_carry   = r_work[w_ridx];
      end
      default: begin
        w_shifted = r_work;
        w_carry   = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_noop ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_rem_next == c_zero) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture at accept, step in SHIFT, publish result on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work      <= '0;
      r_sel       <= c_sel_none;
      r_remaining <= c_zero;
      d_out       <= '0;
      carry_out   <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work      <= d_in;
            r_sel       <= sel;
            r_remaining <= shift_count;
            if (w_noop) begin
              d_out     <= d_in;
              carry_out <= 1'b0;
              zero      <= (d_in == '0);
            end
          end
        end
        S_SHIFT: begin
          r_work      <= w_shifted;
          r_remaining <= w_rem_next;
          if (w_rem_next == c_zero) begin
            d_out     <= w_shifted;
            carry_out <= w_carry;
            zero      <= (w_shifted == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_engine
//  Brief    : Scoreboard bench for shift_engine. Two 8-bit instances, STEP=1
//             (index 0) and STEP=2 (index 1), driven with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_engine;

  localparam int W  = 8;
  localparam int CW = 3;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] LSL  = 3'b001;
  localparam logic [2:0] ASL  = 3'b010;
  localparam logic [2:0] LSR  = 3'b011;
  localparam logic [2:0] ASR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] ROR  = 3'b110;
  localparam logic [2:0] RSVD = 3'b111;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]         in_valid, in_ready, out_valid, out_ready, carry_out, zero;
  logic [1:0][W-1:0]  d_in, d_out;
  logic [1:0][2:0]    sel;
  logic [1:0][CW-1:0] cnt;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int         cyc    = 0;
  int         total  = 0;
  int         passed = 0;
  logic [1:0] prev_v = 2'b00;

  always #5 clk = ~clk;

  // Edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  shift_engine #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .d_in(d_in[0]), .sel(sel[0]), .shift_count(cnt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .d_out(d_out[0]), .carry_out(carry_out[0]), .zero(zero[0])
  );

  shift_engine #(.WIDTH(W), .STEP(2)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .d_in(d_in[1]), .sel(sel[1]), .shift_count(cnt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .d_out(d_out[1]), .carry_out(carry_out[1]), .zero(zero[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the STEP=1 instance
  always @(negedge clk) begin : mon0
    exp_t e;
    if (out_valid[0] && !prev_v[0]) begin
      if (q0.size() == 0) chk("s1_unexpected_out", {31'd0, out_valid[0]}, 32'd0);
      else chk("s1_latency", cyc - q0[0].acc + 1, q0[0].lat);
    end
    if (out_valid[0] && out_ready[0] && q0.size() != 0) begin
      e = q0.pop_front();
      chk("s1_d_out", {24'd0, d_out[0]}, {24'd0, e.data});
      chk("s1_carry", {31'd0, carry_out[0]}, {31'd0, e.carry});
      chk("s1_zero",  {31'd0, zero[0]}, {31'd0, e.zero});
    end
    prev_v[0] = out_valid[0];
  end

  // Monitor for the STEP=2 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (out_valid[1] && !prev_v[1]) begin
      if (q1.size() == 0) chk("s2_unexpected_out", {31'd0, out_valid[1]}, 32'd0);
      else chk("s2_latency", cyc - q1[0].acc + 1, q1[0].lat);
    end
    if (out_valid[1] && out_ready[1] && q1.size() != 0) begin
      e = q1.pop_front();
      chk("s2_d_out", {24'd0, d_out[1]}, {24'd0, e.data});
      chk("s2_carry", {31'd0, carry_out[1]}, {31'd0, e.carry});
      chk("s2_zero",  {31'd0, zero[1]}, {31'd0, e.zero});
    end
    prev_v[1] = out_valid[1];
  end

  // Present one operation, and queue its expected result when push is set
  task automatic issue(input int u, input logic [W-1:0] d, input logic [2:0] s,
                       input logic [CW-1:0] c, input logic [W-1:0] ed,
                       input logic ec, input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) begin
      chk("issue_timeout", {31'd0, in_ready[u]}, 32'd1);
      return;
    end
    in_valid[u] = 1'b1;
    d_in[u]     = d;
    sel[u]      = s;
    cnt[u]      = c;
    @(posedge clk);
    #1;
    if (push) begin
      e = '{data: ed, carry: ec, zero: (ed == '0), acc: cyc, lat: lat};
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    // Scramble inputs after accept; they must not affect the operation
    in_valid[u] = 1'b0;
    d_in[u]     = ~d;
    sel[u]      = ~s;
    cnt[u]      = ~c;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in_ready != 2'b11) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 32'd0);
  endtask

  task automatic chk_reset_state(input int u);
    chk("rst_out_valid", {31'd0, out_valid[u]}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready[u]}, 32'd1);
    chk("rst_d_out",     {24'd0, d_out[u]}, 32'd0);
    chk("rst_carry",     {31'd0, carry_out[u]}, 32'd0);
    chk("rst_zero",      {31'd0, zero[u]}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 2'b11;
    d_in      = '0;
    sel       = '0;
    cnt       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);

    // STEP=1 shifts and rotates
    issue(0, 8'h96, ROL, 3'd3, 8'hB4, 1'b0, 4, 1'b1);
    issue(0, 8'h93, ASR, 3'd2, 8'hE4, 1'b1, 3, 1'b1);
    issue(0, 8'h80, LSL, 3'd1, 8'h00, 1'b1, 2, 1'b1);
    issue(0, 8'h41, ASL, 3'd2, 8'h04, 1'b1, 3, 1'b1);
    issue(0, 8'h01, LSR, 3'd1, 8'h00, 1'b1, 2, 1'b1);
    // No-op paths clear a previously set carry
    issue(0, 8'h5A, NONE, 3'd5, 8'h5A, 1'b0, 1, 1'b1);
    issue(0, 8'h5A, LSL,  3'd0, 8'h5A, 1'b0, 1, 1'b1);
    // STEP=2
    issue(1, 8'hA5, RSVD, 3'd3, 8'hA5, 1'b0, 1, 1'b1);
    issue(1, 8'h00, NONE, 3'd0, 8'h00, 1'b0, 1, 1'b1);
    issue(1, 8'hF0, LSR,  3'd5, 8'h07, 1'b1, 4, 1'b1);
    issue(1, 8'h80, ASR,  3'd7, 8'hFF, 1'b0, 5, 1'b1);
    issue(1, 8'h03, ROR,  3'd3, 8'h60, 1'b0, 3, 1'b1);
    issue(1, 8'h41, ROL,  3'd2, 8'h05, 1'b1, 2, 1'b1);
    drain();

    // Back-pressure: result held while out_ready is low, new input refused
    out_ready[0] = 1'b0;
    issue(0, 8'h1F, LSL, 3'd4, 8'hF0, 1'b1, 5, 1'b1);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid[0]}, 32'd1);
      chk("hold_in_ready",  {31'd0, in_ready[0]}, 32'd0);
      chk("hold_d_out",     {24'd0, d_out[0]}, 32'h0000_00F0);
      chk("hold_carry",     {31'd0, carry_out[0]}, 32'd1);
      chk("hold_zero",      {31'd0, zero[0]}, 32'd0);
      in_valid[0] = (i % 2 == 0);
      d_in[0]     = 8'h33;
      sel[0]      = ROL;
      cnt[0]      = 3'd1;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    drain();
    repeat (4) @(negedge clk);
    chk("no_extra_out", {31'd0, out_valid[0]}, 32'd0);

    // Reset during the third SHIFT cycle aborts the rotate
    issue(0, 8'h01, ROR, 3'd7, 8'h02, 1'b0, 8, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state(0);
    chk("rst_s2_d_out", {24'd0, d_out[1]}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_out", {31'd0, out_valid[0]}, 32'd0);
    chk("abort_d_out",  {24'd0, d_out[0]}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
